// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes over a 128-bit state, LANES bytes per cycle.
//
// Each lane computes the inverse S-box in a composite field GF((2^4)^2)
// instead of using a lookup table. The steps are the inverse affine map,
// the isomorphic map into the composite field, inversion through GF(2^4),
// and the map back to the AES polynomial basis.
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_in     synchronous active-high reset
//   state_in   input state, byte i = state_in[8i+7:8i]
//   valid_in   state_in valid (sampled only in IDLE)
//   ready_out  high exactly in IDLE
//   state_out  InvSubBytes result, meaningful while valid_out is high
//   valid_out  high exactly in DONE
//   ready_in   downstream accepts state_out
module inv_sub_bytes #(
  parameter int LANES = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] state_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [127:0] state_out,
  output logic         valid_out,
  input  logic         ready_in
);

  localparam int GROUPS = 16 / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);
  // y^2 + y + LAMBDA is irreducible over GF(2^4) mod x^4+x+1 (trace of 0xC is 1)
  localparam logic [3:0] LAMBDA = 4'hC;

  // GF(2^4) multiply, polynomial x^4 + x + 1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // a^-1 = a^14 in GF(2^4); zero maps to zero
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8, a6;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    a6 = gf16_mul(a2, a4);
    return gf16_mul(a6, a8);
  endfunction

  // Composite element {h, l} = h*y + l, reduced with y^2 = y + LAMBDA
  function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(a[3:0], b[3:0]) ^ gf16_mul(hh, LAMBDA)};
  endfunction

  // (h*y + l)^-1 = (h*d^-1)*y + (h+l)*d^-1 with d = h^2*LAMBDA + h*l + l^2
  function automatic logic [7:0] gfc_inv(input logic [7:0] a);
    logic [3:0] h, l, d, di;
    h  = a[7:4];
    l  = a[3:0];
    d  = gf16_mul(gf16_mul(h, h), LAMBDA) ^ gf16_mul(h, l) ^ gf16_mul(l, l);
    di = gf16_inv(d);
    return {gf16_mul(h, di), gf16_mul(h ^ l, di)};
  endfunction

  // 8x8 GF(2) matrix times vector; row r lives in m[8r+7:8r]
  function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(m[8*i +: 8] & v);
    return r;
  endfunction

  // Isomorphism matrix: x (0x02 in the AES basis) maps to the first root beta
  // of x^8+x^4+x^3+x+1 found in the composite field; column i holds beta^i.
  function automatic logic [63:0] build_iso();
    logic [7:0]  beta, pw, pv;
    logic [63:0] m;
    logic        found;
    beta  = 8'h00;
    found = 1'b0;
    for (int c = 2; c < 256 && !found; c++) begin
      pw = 8'h01;
      pv = 8'h01;
      for (int e = 1; e <= 8; e++) begin
        pw = gfc_mul(pw, 8'(c));
        if (e == 1 || e == 3 || e == 4 || e == 8) pv = pv ^ pw;
      end
      if (pv == 8'h00) begin
        beta  = 8'(c);
        found = 1'b1;
      end
    end
    m  = '0;
    pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 8; r++) m[8*r + i] = pw[r];
      pw = gfc_mul(pw, beta);
    end
    return m;
  endfunction

  // Inverse map: column j is the AES-basis element whose image is bit j alone
  function automatic logic [63:0] build_iso_inv(input logic [63:0] m);
    logic [63:0] mi;
    logic [7:0]  v, a;
    mi = '0;
    for (int k = 0; k < 256; k++) begin
      a = 8'(k);
      v = mat_apply(m, a);
      for (int j = 0; j < 8; j++) begin
        if (v == 8'(1 << j)) begin
          for (int r = 0; r < 8; r++) mi[8*r + j] = a[r];
        end
      end
    end
    return mi;
  endfunction

  localparam logic [63:0] ISO     = build_iso();
  localparam logic [63:0] ISO_INV = build_iso_inv(ISO);

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t, a;
    t = y ^ 8'h63;
    // inverse affine linear part: rotl1 ^ rotl3 ^ rotl6
    a = {t[6:0], t[7]} ^ {t[4:0], t[7:5]} ^ {t[1:0], t[7:2]};
    return mat_apply(ISO_INV, gfc_inv(mat_apply(ISO, a)));
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     in_reg;
  logic [7:0]       lane_out [LANES];

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_out[j] = inv_sbox(in_reg[8*(LANES*int'(cnt) + j) +: 8]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st        <= IDLE;
      cnt       <= '0;
      in_reg    <= '0;
      state_out <= '0;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (valid_in) begin
            in_reg    <= state_in;
            cnt       <= '0;
            st        <= BUSY;
            ready_out <= 1'b0;
          end
        end
        BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            state_out[8*(LANES*int'(cnt) + j) +: 8] <= lane_out[j];
          end
          if (cnt == LAST) begin
            cnt       <= '0;
            st        <= DONE;
            valid_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready_in) begin
            st        <= IDLE;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: directed bench for inv_sub_bytes (LANES=4 main instance,
// plus LANES=1/2/8/16 instances for the latency sweep). Expected values come
// from hand-written vectors and from a polynomial-basis S-box model built here.
module tb_inv_sub_bytes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] state_in;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] state_out;
  logic         valid_out;
  logic         ready_in;

  inv_sub_bytes #(.LANES(4)) dut (
    .clk_in(clk), .rst_in(rst), .state_in(state_in), .valid_in(valid_in),
    .ready_out(ready_out), .state_out(state_out), .valid_out(valid_out),
    .ready_in(ready_in)
  );

  logic [127:0] sw_state_in;
  logic         sw_valid_in;
  logic         sw_ready_in;
  logic [127:0] sw_state_out [4];
  logic         sw_valid_out [4];
  logic         sw_ready_out [4];

  function automatic int lanes_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    inv_sub_bytes #(.LANES(lanes_of(g))) u_sw (
      .clk_in(clk), .rst_in(rst), .state_in(sw_state_in), .valid_in(sw_valid_in),
      .ready_out(sw_ready_out[g]), .state_out(sw_state_out[g]),
      .valid_out(sw_valid_out[g]), .ready_in(sw_ready_in)
    );
  end

  localparam logic [127:0] VEC     = {96'h0, 8'h16, 8'h76, 8'h7C, 8'h63};
  localparam logic [127:0] VEC_EXP = {{12{8'h52}}, 8'hFF, 8'h0F, 8'h01, 8'h00};

  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: brute-force inverse mod 0x11B plus forward affine map
  logic [7:0] fwd [256];
  logic [7:0] inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  task automatic build_model();
    logic [7:0] x, y, bi;
    for (int i = 0; i < 256; i++) begin
      x  = 8'(i);
      bi = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (x != 8'h00 && gmul(x, y) == 8'h01) bi = y;
      end
      fwd[i] = bi ^ rotl(bi, 1) ^ rotl(bi, 2) ^ rotl(bi, 3) ^ rotl(bi, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv[s[8*i +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until valid_out rises, bounded so a stuck DUT cannot hang the run
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_out && n < 50) begin
      tick();
      n++;
    end
  endtask

  logic [127:0] s, exp_s;
  logic [127:0] exp_q [$];
  logic         seen [256];
  int           n, lat [4], distinct, sent, recv, cyc, extra;
  logic         acc, outp, saw_valid;
  logic [7:0]   ob;

  initial begin
    rst = 1'b1; state_in = '0; valid_in = 1'b0; ready_in = 1'b0;
    sw_state_in = '0; sw_valid_in = 1'b0; sw_ready_in = 1'b0;
    build_model();
    check("model_inv_ED", 128'(inv[8'hED]), 128'h53);
    check("model_inv_00", 128'(inv[8'h00]), 128'h52);

    // Reset state
    tick(); tick();
    check("rst_state_out", state_out, '0);
    check_i("rst_valid_out", int'(valid_out), 0);
    rst = 1'b0;
    tick();
    check_i("post_rst_ready", int'(ready_out), 1);
    check_i("post_rst_sw_ready", int'({sw_ready_out[0], sw_ready_out[1], sw_ready_out[2], sw_ready_out[3]}), 15);

    // Directed vector, LANES=4
    state_in = VEC; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check_i("busy_ready_low", int'(ready_out), 0);
    wait_valid(n);
    check_i("vec_latency", n, 4);
    check("vec_data", state_out, VEC_EXP);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check_i("vec_release_rdy_vld", int'({ready_out, valid_out}), 2);

    // Parameter sweep
    sw_state_in = VEC; sw_valid_in = 1'b1;
    tick();
    sw_valid_in = 1'b0;
    for (int g = 0; g < 4; g++) lat[g] = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 4; g++) if (sw_valid_out[g] && lat[g] < 0) lat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      check_i($sformatf("sweep_latency_L%0d", lanes_of(g)), lat[g], 16 / lanes_of(g));
      check($sformatf("sweep_data_L%0d", lanes_of(g)), sw_state_out[g], VEC_EXP);
    end
    sw_ready_in = 1'b1;
    tick();
    sw_ready_in = 1'b0;
    check_i("sweep_release", int'({sw_valid_out[0], sw_valid_out[1], sw_valid_out[2], sw_valid_out[3]}), 0);

    // Exhaustive: all 256 byte values in 16 states
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16*k + i);
      state_in = s; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      wait_valid(n);
      check_i($sformatf("exh_latency_%0d", k), n, 4);
      check($sformatf("exh_data_%0d", k), state_out, model_state(s));
      for (int i = 0; i < 16; i++) begin
        ob = state_out[8*i +: 8];
        seen[ob] = 1'b1;
      end
      if (k == 14) check("exh_ED", 128'(state_out[8*13 +: 8]), 128'h53);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check_i("exh_bijection", distinct, 256);

    // Backpressure in DONE
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_s = model_state(s);
    state_in = s; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      valid_in = 1'($urandom_range(0, 1));
      state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check($sformatf("bp_data_%0d", c), state_out, exp_s);
      check_i($sformatf("bp_rdy_vld_%0d", c), int'({ready_out, valid_out}), 1);
    end
    valid_in = 1'b1;
    ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    ready_in = 1'b0;
    check_i("bp_release_rdy_vld", int'({ready_out, valid_out}), 2);
    tick();
    check_i("bp_no_accept_on_release", int'(ready_out), 1);

    // Reset in the second BUSY cycle
    state_in = {$urandom(), $urandom(), $urandom(), $urandom()}; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state_out", state_out, '0);
    check_i("midrst_rdy_vld", int'({ready_out, valid_out}), 2);
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid_out) saw_valid = 1'b1;
    end
    check_i("midrst_no_valid", int'(saw_valid), 0);
    state_in = VEC; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    wait_valid(n);
    check_i("midrst_after_latency", n, 4);
    check("midrst_after_data", state_out, VEC_EXP);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;

    // Streaming with random backpressure
    sent = 0; recv = 0; cyc = 0; extra = 0;
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    state_in = s; valid_in = 1'b1;
    while (recv < 100 && cyc < 5000) begin
      ready_in = 1'($urandom_range(0, 1));
      acc  = valid_in && ready_out;
      outp = valid_out && ready_in;
      if (outp) begin
        if (exp_q.size() > 0) check($sformatf("stream_data_%0d", recv), state_out, exp_q.pop_front());
        else extra++;
        recv++;
      end
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(model_state(s));
        sent++;
        if (sent < 100) s = {$urandom(), $urandom(), $urandom(), $urandom()};
        else valid_in = 1'b0;
        state_in = s;
      end
    end
    ready_in = 1'b0;
    valid_in = 1'b0;
    check_i("stream_received", recv, 100);
    check_i("stream_sent", sent, 100);
    check_i("stream_extra", extra, 0);
    check_i("stream_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
